demux_rr_arbiter: RTL and testbench
===================================

// Module: demux_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares the 4-output DEMUX_1x4 / DECODER_2x4 path among four requesters.
//  Drives the shared select bus and the demux data/enable input. Each requester gets a bounded hold
//  window, followed by a dead gap. Sits in top between the pull-up button pins (inverted) and the
//  demux; sel feeds the demux select, en feeds its data input.
// PARAMETERS
//  HOLD_CYCLES  12_000_000  grant window length in CLK cycles (>=1; 0.75 s at 16 MHz)
//  GAP_CYCLES    1_600_000  dead time after each grant, en low (>=0; 0 = skip GAP)
//  CW = $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1)  localparam, counter width
// PORTS
//  CLK    in   1  system clock, all flops rising edge
//  RST_N  in   1  asynchronous, active-low reset
//  req    in   4  requests, active-high (already inverted from pull-up pins), asynchronous to CLK
//  sel    out  2  select to demux/decoder; binary index of the current or last grantee
//  en     out  1  demux data input; high only while a grant is active
//  gnt    out  4  one-hot grant; gnt[sel]==en
//  busy   out  1  high in GRANT and GAP
// BEHAVIOUR
//  - Reset (async, RST_N=0): state=IDLE; sel=0, en=0, gnt=0, busy=0; ptr=0; cnt=0; sync flops=0.
//    Applies immediately, mid-operation included. No clock is needed to clear outputs.
//  - req passes through a 2-flop synchronizer (req_s). Arbitration uses only req_s.
//  - All outputs are registered. Latency from req pin edge to gnt/en is 3 CLK edges.
//  - States: IDLE, GRANT, GAP.
//  - IDLE: busy=0, en=0.
//    If |req_s: idx = first set bit searching ptr, ptr+1, ... mod 4.
//    Load sel=idx, gnt=1<<idx, en=1, busy=1, cnt=HOLD_CYCLES-1. Go to GRANT.
//  - GRANT: cnt decrements each cycle.
//    Exit when cnt==0 or req_s[sel]==0 (early release). On the exit edge:
//      en=0, gnt=0; sel holds; ptr=(sel+1) mod 4, wrapping 3->0.
//      If GAP_CYCLES>0: cnt=GAP_CYCLES-1, go to GAP. Otherwise go to IDLE.
//  - GAP: en=0, busy=1, sel holds; count down; at cnt==0 go to IDLE.
//  - sel never changes while en=1, and only changes on the edge that raises en (glitch-free demux).
//  - Contention: the requester at or after ptr wins. A requester still holding req after its window
//    is re-granted only after all other pending requesters have been served.
//  - Single requester held continuously: repeats HOLD on / GAP off indefinitely.
//  - req changes during GAP are ignored until IDLE evaluates them.
//  - Invariants: gnt is one-hot or zero; (gnt!=0)==en; en implies busy; cnt never underflows.
// STRUCTURE
//  - Shared include arb_defs.vh holds:
//      state encodings ST_IDLE=2'd0, ST_GRANT=2'd1, ST_GAP=2'd2
//      N_REQ=4, SEL_W=2
//  - Sub-module rr_pick: combinational search (req_s[3:0], ptr[1:0]) -> idx[1:0], any.
//  - The rest lives in this module: synchronizer, FSM, counter, output registers.
// TESTING  (bench uses HOLD_CYCLES=4, GAP_CYCLES=2)
//  1. RST_N=0 for 3 cycles with req=1111.
//     -> sel=0, en=0, gnt=0, busy=0 throughout.
//     -> After release: gnt=0001, sel=0 on the 3rd edge.
//  2. req=0100 held.
//     -> 3 edges later: gnt=0100, sel=2, en=1 for 4 cycles.
//     -> Then en=0, busy=1 for 2 cycles, then re-grant ch2.
//  3. req=1111 constant.
//     -> Grant order 0,1,2,3,0. Each grant is 4 cycles en=1 with 2-cycle gaps; sel is stable while en=1.
//  4. req=0010 dropped after 2 grant cycles.
//     -> en/gnt fall 3 edges after the drop (sync + exit).
//     -> GAP of 2 cycles follows, then ptr=2.
//     -> Then req=0011 -> grant ch0 (wrap search).
//  5. Pull RST_N low mid-GRANT of ch3, between clock edges.
//     -> en, gnt, busy go 0 asynchronously.
//     -> After release with req=1001: ch0 is granted first (ptr=0).
//  6. Let ptr=3 with req=1001.
//     -> Grant ch3 then ch0 (3->0 wrap), never ch3 twice in a row.
//  Every test: assert the invariants each cycle.

Source files
------------

// File: rtl/demux_rr_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | demux_rr_arbiter_pkg : shared types, sizes and helpers for the arbiter     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package demux_rr_arbiter_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Modulo-4 successor; the natural 2-bit wrap gives 3 -> 0.
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
        return idx + SEL_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_rr_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_pick : combinational round-robin search starting at i_ptr               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rr_pick
    import demux_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_any
);

    // Walk offsets from far to near so the closest requester at/after i_ptr wins.
    always_comb begin
        o_idx = i_ptr;
        o_any = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_req[i_ptr + SEL_W'(k)]) begin
                o_idx = i_ptr + SEL_W'(k);
                o_any = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/demux_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | demux_rr_arbiter : round-robin owner of the shared demux select/enable     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module demux_rr_arbiter
    import demux_rr_arbiter_pkg::*;
#(
    parameter int HOLD_CYCLES = 12_000_000,
    parameter int GAP_CYCLES  = 1_600_000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_REQ-1:0] req,
    output logic [SEL_W-1:0] sel,
    output logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic             busy
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [N_REQ-1:0] r_req_meta;
    logic [N_REQ-1:0] r_req_s;
    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] w_ptr_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [SEL_W-1:0] w_sel_nxt;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic             w_en_nxt;
    logic             w_busy_nxt;
    logic [SEL_W-1:0] w_pick_idx;
    logic             w_pick_any;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_req_meta <= '0;
            r_req_s    <= '0;
        end else begin
            r_req_meta <= req;
            r_req_s    <= r_req_meta;
        end
    end

    rr_pick u_rr_pick (
        .i_req (r_req_s),
        .i_ptr (r_ptr),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    // sel is only reloaded from IDLE, i.e. on the same edge that raises en.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = sel;
        w_gnt_nxt   = '0;
        w_en_nxt    = 1'b0;
        w_busy_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = ST_GRANT;
                    w_sel_nxt   = w_pick_idx;
                    w_gnt_nxt   = onehot(w_pick_idx);
                    w_en_nxt    = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = HOLD_LOAD;
                end
            end
            ST_GRANT: begin
                if (r_cnt == '0 || !r_req_s[sel]) begin
                    w_ptr_nxt = next_idx(sel);
                    if (GAP_CYCLES > 0) begin
                        w_state_nxt = ST_GAP;
                        w_cnt_nxt   = GAP_LOAD;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end else begin
                    w_cnt_nxt  = r_cnt - CW'(1);
                    w_gnt_nxt  = gnt;
                    w_en_nxt   = 1'b1;
                    w_busy_nxt = 1'b1;
                end
            end
            ST_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt  = r_cnt - CW'(1);
                    w_busy_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            sel     <= '0;
            en      <= 1'b0;
            gnt     <= '0;
            busy    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            sel     <= w_sel_nxt;
            en      <= w_en_nxt;
            gnt     <= w_gnt_nxt;
            busy    <= w_busy_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_demux_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_demux_rr_arbiter : scoreboard bench for demux_rr_arbiter (HOLD=4,GAP=2) |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_demux_rr_arbiter;

    localparam int HOLD = 4;
    localparam int GAP  = 2;

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b1;
    logic [3:0] req   = 4'b0000;
    logic [1:0] sel;
    logic       en;
    logic [3:0] gnt;
    logic       busy;

    typedef struct {
        logic [1:0] ch;
        int         len;   // 0 = grant is cut short by the test, length not checked
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    bit         in_grant = 1'b0;
    bit         in_gap   = 1'b0;
    bit         prev_en  = 1'b0;
    exp_t       cur;
    int         grant_len = 0;
    int         gap_len   = 0;
    logic [1:0] grant_sel = 2'd0;

    demux_rr_arbiter #(
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .req   (req),
        .sel   (sel),
        .en    (en),
        .gnt   (gnt),
        .busy  (busy)
    );

    always #5 CLK = ~CLK;

    // Output monitor: invariants every cycle, grant order/length and gap length.
    always @(negedge CLK) begin
        if (!RST_N) begin
            in_grant = 1'b0;
            in_gap   = 1'b0;
            prev_en  = 1'b0;
        end else begin
            checks++;
            if (!(((gnt & (gnt - 4'd1)) == 4'd0) && ((gnt != 4'd0) == en) &&
                  (!en || busy) && (gnt[sel] == en))) begin
                errors++;
                $display("FAIL invariant: gnt=%b sel=%0d en=%b busy=%b", gnt, sel, en, busy);
            end
            if (in_gap) begin
                if (busy && !en) begin
                    gap_len++;
                end else begin
                    checks++;
                    if (gap_len != GAP) begin
                        errors++;
                        $display("FAIL gap_len: got %0d expected %0d", gap_len, GAP);
                    end
                    in_gap = 1'b0;
                end
            end
            if (en && !prev_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL grant_order: unexpected grant sel=%0d gnt=%b, expected none", sel, gnt);
                    cur = '{ch: sel, len: 0};
                end else begin
                    cur = exp_q.pop_front();
                    if (sel !== cur.ch || gnt !== (4'b0001 << cur.ch)) begin
                        errors++;
                        $display("FAIL grant_order: got sel=%0d gnt=%b expected sel=%0d", sel, gnt, cur.ch);
                    end
                end
                in_grant  = 1'b1;
                grant_len = 1;
                grant_sel = sel;
            end else if (en && in_grant) begin
                grant_len++;
                checks++;
                if (sel !== grant_sel) begin
                    errors++;
                    $display("FAIL sel_stable: got sel=%0d expected %0d", sel, grant_sel);
                end
            end
            if (!en && prev_en && in_grant) begin
                if (cur.len != 0) begin
                    checks++;
                    if (grant_len != cur.len) begin
                        errors++;
                        $display("FAIL grant_len ch%0d: got %0d expected %0d", cur.ch, grant_len, cur.len);
                    end
                end
                in_grant = 1'b0;
                in_gap   = 1'b1;
                gap_len  = busy ? 1 : 0;
            end
            prev_en = en;
        end
    end

    task automatic do_reset;
        @(negedge CLK);
        RST_N = 1'b0;
        req   = 4'b0000;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        exp_q.delete();
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n = 0;
        while ((exp_q.size() != 0 || in_grant) && n < budget) begin
            @(negedge CLK);
            #1;
            n++;
        end
        ok = (exp_q.size() == 0) && !in_grant;
    endtask

    task automatic wait_en(input logic level, input int budget, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!ok && n < budget) begin
            @(negedge CLK);
            n++;
            if (en === level) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        #1 RST_N = 1'b0;
        req = 4'b1111;
        repeat (3) begin
            @(negedge CLK);
            checks++;
            if (sel !== 2'd0 || en !== 1'b0 || gnt !== 4'd0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: sel=%0d en=%b gnt=%b busy=%b expected all 0", sel, en, gnt, busy);
            end
        end
        exp_q.push_back('{ch: 2'd0, len: 0});
        RST_N = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(negedge CLK);
            checks++;
            if (e < 3) begin
                if (gnt !== 4'd0 || en !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_latency edge%0d: gnt=%b en=%b expected 0000/0", e, gnt, en);
                end
            end else if (gnt !== 4'b0001 || sel !== 2'd0 || en !== 1'b1) begin
                errors++;
                $display("FAIL reset_first_grant: gnt=%b sel=%0d en=%b expected 0001/0/1", gnt, sel, en);
            end
        end
        do_reset();
    endtask

    task automatic test_single_hold;
        bit ok;
        exp_q.push_back('{ch: 2'd2, len: HOLD});
        exp_q.push_back('{ch: 2'd2, len: HOLD});
        @(negedge CLK);
        req = 4'b0100;
        for (int e = 1; e <= 3; e++) begin
            @(negedge CLK);
            checks++;
            if (e < 3) begin
                if (en !== 1'b0) begin
                    errors++;
                    $display("FAIL single_latency edge%0d: en=%b expected 0", e, en);
                end
            end else if (gnt !== 4'b0100 || sel !== 2'd2 || en !== 1'b1) begin
                errors++;
                $display("FAIL single_grant: gnt=%b sel=%0d en=%b expected 0100/2/1", gnt, sel, en);
            end
        end
        wait_done(60, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_done: pending=%0d expected 0", exp_q.size());
        end
        do_reset();
    endtask

    task automatic test_round_robin;
        bit ok;
        for (int i = 0; i < 5; i++) exp_q.push_back('{ch: 2'(i % 4), len: HOLD});
        @(negedge CLK);
        req = 4'b1111;
        wait_done(120, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rr_done: pending=%0d expected 0", exp_q.size());
        end
        do_reset();
    endtask

    task automatic test_early_release;
        bit ok;
        exp_q.push_back('{ch: 2'd1, len: 3});
        @(negedge CLK);
        req = 4'b0010;
        wait_en(1'b1, 20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL early_grant: en=%b expected 1 within bound", en);
        end
        req = 4'b0000;
        for (int e = 1; e <= 3; e++) begin
            @(negedge CLK);
            checks++;
            if (e < 3) begin
                if (en !== 1'b1) begin
                    errors++;
                    $display("FAIL early_hold edge%0d: en=%b expected 1", e, en);
                end
            end else if (en !== 1'b0 || gnt !== 4'd0 || busy !== 1'b1 || sel !== 2'd1) begin
                errors++;
                $display("FAIL early_drop: en=%b gnt=%b busy=%b sel=%0d expected 0/0000/1/1", en, gnt, busy, sel);
            end
        end
        req = 4'b0011;
        exp_q.push_back('{ch: 2'd0, len: HOLD});
        exp_q.push_back('{ch: 2'd1, len: HOLD});
        wait_done(80, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL early_wrap_done: pending=%0d expected 0", exp_q.size());
        end
        do_reset();
    endtask

    task automatic test_async_reset;
        bit ok;
        exp_q.push_back('{ch: 2'd3, len: 0});
        @(negedge CLK);
        req = 4'b1000;
        wait_en(1'b1, 20, ok);
        checks++;
        if (!ok || gnt !== 4'b1000) begin
            errors++;
            $display("FAIL async_pre_grant: en=%b gnt=%b expected 1/1000", en, gnt);
        end
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if (en !== 1'b0 || gnt !== 4'd0 || busy !== 1'b0 || sel !== 2'd0) begin
            errors++;
            $display("FAIL async_clear: en=%b gnt=%b busy=%b sel=%0d expected all 0", en, gnt, busy, sel);
        end
        req = 4'b1001;
        exp_q.push_back('{ch: 2'd0, len: HOLD});
        exp_q.push_back('{ch: 2'd3, len: HOLD});
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        wait_done(80, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL async_after_done: pending=%0d expected 0", exp_q.size());
        end
        do_reset();
    endtask

    task automatic test_ptr_wrap;
        bit ok;
        exp_q.push_back('{ch: 2'd2, len: HOLD});
        @(negedge CLK);
        req = 4'b0100;
        wait_en(1'b1, 20, ok);
        if (ok) wait_en(1'b0, 20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wrap_setup: en=%b expected a full ch2 grant", en);
        end
        req = 4'b1001;
        exp_q.push_back('{ch: 2'd3, len: HOLD});
        exp_q.push_back('{ch: 2'd0, len: HOLD});
        exp_q.push_back('{ch: 2'd3, len: HOLD});
        wait_done(150, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wrap_done: pending=%0d expected 0", exp_q.size());
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single_hold();
        test_round_robin();
        test_early_release();
        test_async_reset();
        test_ptr_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
